commit_watchdog: RTL and testbench
==================================

// Module: commit_watchdog
// PURPOSE
//   Synthesizable run monitor for the singlecycle core, replacing ad-hoc bench-side watchdog loops.
//   Taps the core's instruction-valid strobe and debug PC, counts cycles and retired instructions,
//   and emits a periodic report pulse. Classifies the run as HALT (pass: self-loop), HUNG (no retire)
//   or TIMEOUT (cycle budget spent). Sits beside singlecycle in benches and on FPGA (status to LEDs).
// PARAMETERS
//   CNT_W          32    width of cycle/retire counters (saturating)
//   PC_W           32    PC width
//   TIMEOUT        64    consecutive no-retire cycles in RUN -> HUNG (>=1)
//   LOOP_N         4     consecutive retires of identical PC -> HALT (>=2)
//   MAX_CYCLES     2000  RUN cycle budget -> TIMEOUT (>=1)
//   REPORT_PERIOD  100   o_report period in RUN cycles; 0 disables reporting
//   HIST_DEPTH     8     PC history entries (power of 2, >=2); used only with COMMIT_WD_HIST_EN
// PORTS
//   i_clk         in   1                   clock
//   i_rst         in   1                   synchronous reset, active-high
//   i_enable      in   1                   start monitoring; sampled only in IDLE
//   i_insn_vld    in   1                   one instruction retired this cycle
//   i_pc          in   PC_W                PC of retiring instruction (valid with i_insn_vld)
//   i_hist_idx    in   $clog2(HIST_DEPTH)  history read index, 0 = most recent retire
//   o_state       out  3                   commit_wd_pkg::wd_state_e
//   o_done        out  1                   state is HALT, HUNG or TIMEOUT
//   o_pass        out  1                   state is HALT
//   o_report      out  1                   one-cycle periodic report pulse
//   o_cycle_cnt   out  CNT_W               RUN cycles elapsed
//   o_retire_cnt  out  CNT_W               instructions retired in RUN
//   o_last_pc     out  PC_W                PC of most recent retire
//   o_hist_pc     out  PC_W                history entry at i_hist_idx
// BEHAVIOUR
//   - Reset (sync, takes effect at the edge with i_rst=1, incl. mid-run): state IDLE; all counters,
//     o_last_pc, repeat/idle counters, history and o_report = 0. Reset overrides all other inputs.
//   - IDLE: counters hold; i_insn_vld ignored; i_enable=1 -> RUN at next edge.
//   - RUN, every edge: cycle_cnt+1. If i_insn_vld: retire_cnt+1, last_pc<=i_pc, idle_cnt<=0,
//     rep_cnt <= (retire_cnt!=0 && i_pc==last_pc) ? rep_cnt+1 : 0. Else idle_cnt+1.
//     i_enable ignored in RUN.
//   - Terminal transitions, evaluated on pre-edge values, all taken at the same edge as the updates:
//       HALT    : i_insn_vld && i_pc==last_pc && retire_cnt!=0 && rep_cnt==LOOP_N-2
//       HUNG    : !i_insn_vld && idle_cnt==TIMEOUT-1
//       TIMEOUT : cycle_cnt==MAX_CYCLES-1
//     Priority on coincidence: HALT > HUNG > TIMEOUT. The triggering cycle's counter updates are applied.
//   - Terminal states are sticky until i_rst; counters and history freeze; o_report=0.
//   - o_done/o_pass are decoded combinationally from the state register.
//   - o_report: registered; 1 for the cycle after the edge where updated cycle_cnt % REPORT_PERIOD==0.
//     Implemented with a dedicated period counter, no divider. Fires on the terminal edge if aligned.
//   - Counters saturate at all-ones; no wrap.
//   - Latency: all outputs registered except o_done/o_pass (state decode) and o_hist_pc (comb read).
// CONFIGURATION
//   COMMIT_WD_HIST_EN defined: HIST_DEPTH-entry ring of retired PCs.
//     Write pointer advances on each RUN retire; overwrites oldest on wrap.
//     o_hist_pc = PC retired i_hist_idx retires ago; entries not yet written read 0.
//   Undefined: no ring storage; o_hist_pc tied to 0; i_hist_idx unused. All other behaviour identical.
// STRUCTURE
//   commit_wd_pkg: typedef enum logic [2:0] wd_state_e {WD_IDLE=0, WD_RUN=1, WD_HALT=2, WD_HUNG=3,
//     WD_TIMEOUT=4}; localparam helpers for saturation max.
//   Sub-module pc_hist_ring (DEPTH, W): write-enable, data, read index, read data.
//     Instantiated only under COMMIT_WD_HIST_EN.
// TESTING (defaults unless noted)
//   1. rst 4 cycles, i_enable=1 pulse, vld every cycle PC=0,4,8.. -> o_report high 1 cycle when
//      cycle_cnt==100; retire_cnt==100; state RUN.
//   2. Retire PCs 0x10, 0x40, 0x40, 0x40, 0x40 -> HALT at the edge of the 4th 0x40; o_pass=1;
//      retire_cnt==5 thereafter, frozen.
//   3. One retire, then i_insn_vld=0 -> HUNG exactly 64 cycles later; o_done=1, o_pass=0.
//   4. Alternate PC 0x0/0x4 every cycle -> TIMEOUT when cycle_cnt==2000. MAX_CYCLES=8, LOOP_N=2,
//      repeat PC on cycle 8 -> HALT wins.
//   5. HIST_EN: retire 0x00..0x24 step 4 -> idx0=0x24, idx7=0x08. Without macro -> o_hist_pc==0.
//   6. i_rst mid-RUN and in HUNG -> next cycle IDLE, all counters/outputs 0; i_insn_vld in IDLE
//      leaves retire_cnt 0.

Source files
------------

// File: rtl/commit_wd_pkg.sv
// commit_wd_pkg
//   Shared types and helpers for the commit watchdog.
//   - wd_state_e : watchdog state encoding, also driven out on o_state
//   - is_terminal: true for the three sticky end-of-run states
package commit_wd_pkg;

  localparam int WD_STATE_W = 3;

  typedef enum logic [WD_STATE_W-1:0] {
    WD_IDLE    = 3'd0,
    WD_RUN     = 3'd1,
    WD_HALT    = 3'd2,
    WD_HUNG    = 3'd3,
    WD_TIMEOUT = 3'd4
  } wd_state_e;

  function automatic logic is_terminal(input wd_state_e s);
    return (s == WD_HALT) || (s == WD_HUNG) || (s == WD_TIMEOUT);
  endfunction

endpackage

// File: rtl/pc_hist_ring.sv
// pc_hist_ring
//   Ring buffer of the most recent retired PCs. Every write lands at the
//   write pointer and advances it, overwriting the oldest entry on wrap.
//   Reads are combinational and relative to the newest entry.
// Ports
//   clk   in  1               clock
//   rst   in  1               synchronous reset, active-high; clears all entries
//   we    in  1               write enable (one retire)
//   wdata in  W               PC to store
//   ridx  in  $clog2(DEPTH)   read index, 0 = most recent write
//   rdata out W               entry written ridx writes ago (0 if never written)
module pc_hist_ring #(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] ridx,
  output logic [W-1:0]             rdata
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [IDX_W-1:0] wptr;
  logic [IDX_W-1:0] rptr;

  // Storage is cleared on reset so entries not yet written read back as 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wptr <= '0;
    end else if (we) begin
      mem[wptr] <= wdata;
      wptr      <= wptr + IDX_W'(1);
    end
  end

  // DEPTH is a power of two, so pointer arithmetic wraps naturally.
  assign rptr  = wptr - IDX_W'(1) - ridx;
  assign rdata = mem[rptr];

endmodule

// File: rtl/commit_watchdog.sv
// commit_watchdog
//   Run monitor for the single-cycle core. Counts RUN cycles and retired
//   instructions, pulses o_report periodically and classifies the run as
//   HALT (self-loop), HUNG (no retires for TIMEOUT cycles) or TIMEOUT
//   (cycle budget spent). Terminal states are sticky until i_rst.
//   Optional feature macro: COMMIT_WD_HIST_EN adds a HIST_DEPTH-entry ring
//   of retired PCs readable through i_hist_idx/o_hist_pc; without it
//   o_hist_pc is tied to 0.
// Ports
//   i_clk         in   1      clock
//   i_rst         in   1      synchronous reset, active-high
//   i_enable      in   1      start monitoring (sampled only in IDLE)
//   i_insn_vld    in   1      one instruction retired this cycle
//   i_pc          in   PC_W   PC of retiring instruction
//   i_hist_idx    in   log2   history read index, 0 = most recent retire
//   o_state       out  3      current wd_state_e
//   o_done        out  1      state is HALT, HUNG or TIMEOUT
//   o_pass        out  1      state is HALT
//   o_report      out  1      one-cycle periodic report pulse
//   o_cycle_cnt   out  CNT_W  RUN cycles elapsed
//   o_retire_cnt  out  CNT_W  instructions retired in RUN
//   o_last_pc     out  PC_W   PC of most recent retire
//   o_hist_pc     out  PC_W   history entry at i_hist_idx
module commit_watchdog
  import commit_wd_pkg::*;
#(
  parameter int CNT_W         = 32,
  parameter int PC_W          = 32,
  parameter int TIMEOUT       = 64,
  parameter int LOOP_N        = 4,
  parameter int MAX_CYCLES    = 2000,
  parameter int REPORT_PERIOD = 100,
  parameter int HIST_DEPTH    = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_enable,
  input  logic                          i_insn_vld,
  input  logic [PC_W-1:0]               i_pc,
  input  logic [$clog2(HIST_DEPTH)-1:0] i_hist_idx,
  output logic [WD_STATE_W-1:0]         o_state,
  output logic                          o_done,
  output logic                          o_pass,
  output logic                          o_report,
  output logic [CNT_W-1:0]              o_cycle_cnt,
  output logic [CNT_W-1:0]              o_retire_cnt,
  output logic [PC_W-1:0]               o_last_pc,
  output logic [PC_W-1:0]               o_hist_pc
);

  localparam logic [CNT_W-1:0] CNT_MAX      = '1;
  localparam logic [CNT_W-1:0] IDLE_LAST    = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] REP_LAST     = CNT_W'(LOOP_N - 2);
  localparam logic [CNT_W-1:0] CYCLE_LAST   = CNT_W'(MAX_CYCLES - 1);
  localparam int               PER_W        = (REPORT_PERIOD > 1) ? $clog2(REPORT_PERIOD) : 1;
  localparam int               PER_LAST_I   = (REPORT_PERIOD > 0) ? REPORT_PERIOD - 1 : 0;
  localparam logic [PER_W-1:0] PER_LAST     = PER_W'(PER_LAST_I);

  wd_state_e        state_q;
  wd_state_e        state_d;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] retire_cnt;
  logic [CNT_W-1:0] idle_cnt;
  logic [CNT_W-1:0] rep_cnt;
  logic [PC_W-1:0]  last_pc;
  logic [PER_W-1:0] per_cnt;
  logic             report_r;
  logic             same_pc;
  logic             halt_hit;
  logic             hung_hit;
  logic             timeout_hit;
  logic             hist_we;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Terminal conditions look only at pre-edge counter values, so they line
  // up with the counter updates committed at the same edge.
  assign same_pc     = i_insn_vld && (retire_cnt != '0) && (i_pc == last_pc);
  assign halt_hit    = same_pc && (rep_cnt == REP_LAST);
  assign hung_hit    = !i_insn_vld && (idle_cnt == IDLE_LAST);
  assign timeout_hit = (cycle_cnt == CYCLE_LAST);
  assign hist_we     = (state_q == WD_RUN) && i_insn_vld;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= WD_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; on coincidence HALT beats HUNG beats TIMEOUT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WD_IDLE: begin
        if (i_enable) state_d = WD_RUN;
      end
      WD_RUN: begin
        if (halt_hit)         state_d = WD_HALT;
        else if (hung_hit)    state_d = WD_HUNG;
        else if (timeout_hit) state_d = WD_TIMEOUT;
      end
      default: state_d = state_q;
    endcase
  end

  // Status outputs decoded straight from the state register.
  always_comb begin
    o_state = state_q;
    o_done  = is_terminal(state_q);
    o_pass  = (state_q == WD_HALT);
  end

  // Counters only move in RUN, including the edge that enters a terminal
  // state. The report pulse comes from a period counter that tracks
  // cycle_cnt modulo REPORT_PERIOD, avoiding a divider.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cycle_cnt  <= '0;
      retire_cnt <= '0;
      idle_cnt   <= '0;
      rep_cnt    <= '0;
      last_pc    <= '0;
      per_cnt    <= '0;
      report_r   <= 1'b0;
    end else if (state_q == WD_RUN) begin
      cycle_cnt <= sat_inc(cycle_cnt);
      if (i_insn_vld) begin
        retire_cnt <= sat_inc(retire_cnt);
        last_pc    <= i_pc;
        idle_cnt   <= '0;
        rep_cnt    <= same_pc ? sat_inc(rep_cnt) : '0;
      end else begin
        idle_cnt <= sat_inc(idle_cnt);
      end
      if ((REPORT_PERIOD != 0) && (per_cnt == PER_LAST)) begin
        per_cnt  <= '0;
        report_r <= 1'b1;
      end else begin
        per_cnt  <= per_cnt + PER_W'(1);
        report_r <= 1'b0;
      end
    end else begin
      report_r <= 1'b0;
    end
  end

  assign o_report     = report_r;
  assign o_cycle_cnt  = cycle_cnt;
  assign o_retire_cnt = retire_cnt;
  assign o_last_pc    = last_pc;

`ifdef COMMIT_WD_HIST_EN
  pc_hist_ring #(
    .DEPTH (HIST_DEPTH),
    .W     (PC_W)
  ) u_hist (
    .clk   (i_clk),
    .rst   (i_rst),
    .we    (hist_we),
    .wdata (i_pc),
    .ridx  (i_hist_idx),
    .rdata (o_hist_pc)
  );
`else
  logic unused_hist;
  assign unused_hist = ^{i_hist_idx, hist_we};
  assign o_hist_pc   = '0;
`endif

endmodule

// File: tb/tb_commit_watchdog.sv
// tb_commit_watchdog
//   Directed bench for commit_watchdog with default parameters. Stimulus
//   pushes expected values into a scoreboard; a monitor on the falling edge
//   pops and compares them, and separately checks every o_report pulse
//   against a queue of expected cycle counts.
module tb_commit_watchdog;

  typedef enum int {S_STATE, S_DONE, S_PASS, S_REPORT, S_CYC, S_RET, S_LAST, S_HIST} sig_e;

  localparam logic [31:0] ST_IDLE = 32'd0;
  localparam logic [31:0] ST_RUN  = 32'd1;
  localparam logic [31:0] ST_HALT = 32'd2;
  localparam logic [31:0] ST_HUNG = 32'd3;
  localparam logic [31:0] ST_TOUT = 32'd4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        insn_vld = 1'b0;
  logic [31:0] pc = '0;
  logic [2:0]  hist_idx = '0;
  logic [2:0]  state;
  logic        done;
  logic        pass;
  logic        report;
  logic [31:0] cycle_cnt;
  logic [31:0] retire_cnt;
  logic [31:0] last_pc;
  logic [31:0] hist_pc;

  int cyc = 0;
  int tests_run = 0;
  int failed = 0;

  string       name_q[$];
  sig_e        sig_q[$];
  logic [31:0] val_q[$];
  int          at_q[$];
  int          report_q[$];

  logic [31:0] halt_pcs [5] = '{32'h10, 32'h40, 32'h40, 32'h40, 32'h40};

  commit_watchdog dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_enable     (enable),
    .i_insn_vld   (insn_vld),
    .i_pc         (pc),
    .i_hist_idx   (hist_idx),
    .o_state      (state),
    .o_done       (done),
    .o_pass       (pass),
    .o_report     (report),
    .o_cycle_cnt  (cycle_cnt),
    .o_retire_cnt (retire_cnt),
    .o_last_pc    (last_pc),
    .o_hist_pc    (hist_pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] sample(input sig_e s);
    case (s)
      S_STATE:  return {29'd0, state};
      S_DONE:   return {31'd0, done};
      S_PASS:   return {31'd0, pass};
      S_REPORT: return {31'd0, report};
      S_CYC:    return cycle_cnt;
      S_RET:    return retire_cnt;
      S_LAST:   return last_pc;
      default:  return hist_pc;
    endcase
  endfunction

  // Scoreboard monitor: compares every expectation due this cycle, then
  // checks any report pulse against the expected cycle count queue.
  always @(negedge clk) begin
    while (at_q.size() > 0 && at_q[0] <= cyc) begin
      string       n;
      sig_e        s;
      logic [31:0] v;
      int          a;
      logic [31:0] got;
      n = name_q.pop_front();
      s = sig_q.pop_front();
      v = val_q.pop_front();
      a = at_q.pop_front();
      got = sample(s);
      tests_run++;
      if (a < cyc) begin
        failed++;
        $display("[TB] FAIL %s: stale at cycle %0d, due %0d", n, cyc, a);
      end else if (got !== v) begin
        failed++;
        $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", n, got, v);
      end
    end
    if (report === 1'b1) begin
      tests_run++;
      if (report_q.size() == 0) begin
        failed++;
        $display("[TB] FAIL report_unexpected: o_report=1 at cycle_cnt=%0d, expected no pulse", cycle_cnt);
      end else begin
        int e;
        e = report_q.pop_front();
        if (cycle_cnt !== 32'(e)) begin
          failed++;
          $display("[TB] FAIL report_cycle: pulse at cycle_cnt=%0d, expected %0d", cycle_cnt, e);
        end
      end
    end
  end

  // Drive one cycle of inputs across one rising edge.
  task automatic applyStimulus(input logic r, input logic e, input logic v, input logic [31:0] p);
    rst      = r;
    enable   = e;
    insn_vld = v;
    pc       = p;
    @(posedge clk);
    #1;
  endtask

  // Queue an expectation for the current cycle.
  task automatic checkOutput(input string n, input sig_e s, input logic [31:0] v);
    name_q.push_back(n);
    sig_q.push_back(s);
    val_q.push_back(v);
    at_q.push_back(cyc);
  endtask

  task automatic resetCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, '0);
  endtask

  task automatic startRun();
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
  endtask

  task automatic idleStep();
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    // Reset state and the first report at cycle 100.
    resetCycles(4);
    checkOutput("rst_state", S_STATE, ST_IDLE);
    checkOutput("rst_cycle", S_CYC, 32'd0);
    checkOutput("rst_retire", S_RET, 32'd0);
    checkOutput("rst_last_pc", S_LAST, 32'd0);
    checkOutput("rst_report", S_REPORT, 32'd0);
    checkOutput("rst_done", S_DONE, 32'd0);
    checkOutput("rst_hist", S_HIST, 32'd0);
    startRun();
    checkOutput("run_entry_state", S_STATE, ST_RUN);
    checkOutput("run_entry_cycle", S_CYC, 32'd0);
    for (int k = 1; k <= 100; k++) begin
      if (k % 100 == 0) report_q.push_back(k);
      applyStimulus(1'b0, 1'b0, 1'b1, 32'(4 * (k - 1)));
    end
    checkOutput("t1_cycle", S_CYC, 32'd100);
    checkOutput("t1_retire", S_RET, 32'd100);
    checkOutput("t1_state", S_STATE, ST_RUN);
    checkOutput("t1_last_pc", S_LAST, 32'h18C);
    checkOutput("t1_report", S_REPORT, 32'd1);

    // Self-loop detection: HALT on the fourth consecutive 0x40.
    resetCycles(2);
    startRun();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, halt_pcs[i]);
      if (i == 3) checkOutput("t2_pre_halt_state", S_STATE, ST_RUN);
    end
    checkOutput("t2_state", S_STATE, ST_HALT);
    checkOutput("t2_pass", S_PASS, 32'd1);
    checkOutput("t2_done", S_DONE, 32'd1);
    checkOutput("t2_retire", S_RET, 32'd5);
    checkOutput("t2_cycle", S_CYC, 32'd5);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b1, 32'h40);
    checkOutput("t2_frozen_retire", S_RET, 32'd5);
    checkOutput("t2_frozen_cycle", S_CYC, 32'd5);
    checkOutput("t2_frozen_state", S_STATE, ST_HALT);

    // No-retire detection: HUNG exactly 64 cycles after the last retire.
    resetCycles(2);
    startRun();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h20);
    for (int k = 2; k <= 64; k++) idleStep();
    checkOutput("t3_pre_hung_state", S_STATE, ST_RUN);
    checkOutput("t3_pre_hung_cycle", S_CYC, 32'd64);
    idleStep();
    checkOutput("t3_state", S_STATE, ST_HUNG);
    checkOutput("t3_done", S_DONE, 32'd1);
    checkOutput("t3_pass", S_PASS, 32'd0);
    checkOutput("t3_cycle", S_CYC, 32'd65);
    checkOutput("t3_retire", S_RET, 32'd1);

    // Reset from HUNG, then retires in IDLE are ignored.
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    checkOutput("t6_hung_rst_state", S_STATE, ST_IDLE);
    checkOutput("t6_hung_rst_cycle", S_CYC, 32'd0);
    checkOutput("t6_hung_rst_retire", S_RET, 32'd0);
    checkOutput("t6_hung_rst_done", S_DONE, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h44);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h44);
    checkOutput("t6_idle_retire", S_RET, 32'd0);
    checkOutput("t6_idle_last_pc", S_LAST, 32'd0);
    checkOutput("t6_idle_state", S_STATE, ST_IDLE);

    // Reset mid-RUN overrides a concurrent retire.
    startRun();
    for (int k = 1; k <= 10; k++) applyStimulus(1'b0, 1'b0, 1'b1, 32'(32'h100 + 4 * k));
    checkOutput("t6_run_retire", S_RET, 32'd10);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h200);
    checkOutput("t6_run_rst_state", S_STATE, ST_IDLE);
    checkOutput("t6_run_rst_cycle", S_CYC, 32'd0);
    checkOutput("t6_run_rst_retire", S_RET, 32'd0);
    checkOutput("t6_run_rst_last_pc", S_LAST, 32'd0);
    checkOutput("t6_run_rst_hist", S_HIST, 32'd0);

    // Cycle budget: alternating PCs never loop, TIMEOUT at cycle 2000.
    resetCycles(2);
    startRun();
    for (int k = 1; k <= 2000; k++) begin
      if (k % 100 == 0) report_q.push_back(k);
      applyStimulus(1'b0, 1'b0, 1'b1, (k % 2 == 1) ? 32'h0 : 32'h4);
      if (k == 1999) checkOutput("t4_pre_tout_state", S_STATE, ST_RUN);
    end
    checkOutput("t4_state", S_STATE, ST_TOUT);
    checkOutput("t4_done", S_DONE, 32'd1);
    checkOutput("t4_pass", S_PASS, 32'd0);
    checkOutput("t4_cycle", S_CYC, 32'd2000);
    checkOutput("t4_retire", S_RET, 32'd2000);
    idleStep();
    checkOutput("t4_frozen_report", S_REPORT, 32'd0);
    checkOutput("t4_frozen_cycle", S_CYC, 32'd2000);

    // HALT and TIMEOUT at the same edge: HALT wins.
    resetCycles(2);
    startRun();
    for (int k = 1; k <= 2000; k++) begin
      if (k % 100 == 0) report_q.push_back(k);
      if (k <= 1996) applyStimulus(1'b0, 1'b0, 1'b1, (k % 2 == 1) ? 32'h0 : 32'h4);
      else           applyStimulus(1'b0, 1'b0, 1'b1, 32'h100);
      if (k == 1999) checkOutput("t4b_pre_state", S_STATE, ST_RUN);
    end
    checkOutput("t4b_state", S_STATE, ST_HALT);
    checkOutput("t4b_pass", S_PASS, 32'd1);
    checkOutput("t4b_cycle", S_CYC, 32'd2000);

    // PC history ring (reads 0 when the feature is compiled out).
    resetCycles(2);
    startRun();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h00);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h04);
    hist_idx = 3'd0;
`ifdef COMMIT_WD_HIST_EN
    checkOutput("t5_early_idx0", S_HIST, 32'h04);
`else
    checkOutput("t5_early_idx0", S_HIST, 32'h00);
`endif
    idleStep();
    hist_idx = 3'd5;
    checkOutput("t5_unwritten_idx5", S_HIST, 32'h00);
    for (int k = 2; k < 10; k++) applyStimulus(1'b0, 1'b0, 1'b1, 32'(4 * k));
    hist_idx = 3'd0;
`ifdef COMMIT_WD_HIST_EN
    checkOutput("t5_idx0", S_HIST, 32'h24);
`else
    checkOutput("t5_idx0", S_HIST, 32'h00);
`endif
    idleStep();
    hist_idx = 3'd1;
`ifdef COMMIT_WD_HIST_EN
    checkOutput("t5_idx1", S_HIST, 32'h20);
`else
    checkOutput("t5_idx1", S_HIST, 32'h00);
`endif
    idleStep();
    hist_idx = 3'd7;
`ifdef COMMIT_WD_HIST_EN
    checkOutput("t5_idx7", S_HIST, 32'h08);
`else
    checkOutput("t5_idx7", S_HIST, 32'h00);
`endif
    idleStep();
    checkOutput("t5_last_pc", S_LAST, 32'h24);
    idleStep();
    idleStep();

    if (at_q.size() != 0) begin
      tests_run += at_q.size();
      failed    += at_q.size();
      $display("[TB] FAIL pending_checks: %0d left, expected 0", at_q.size());
    end
    if (report_q.size() != 0) begin
      tests_run += report_q.size();
      failed    += report_q.size();
      $display("[TB] FAIL report_missing: %0d pulses not seen, expected 0", report_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
